// File: rtl/slot_alloc.sv
// Free-list slot allocator: offers the priority free slot combinationally from the registered busy vector.
// Zero-latency offer, one grant per cycle via req/ack (no release bypass); releases take effect next cycle.
`ifndef DISABLE
`define DISABLE 1'b0
`endif
`ifndef ENABLE
`define ENABLE 1'b1
`endif

module slot_alloc #(
  parameter int DEPTH = 16,
  parameter bit MSB   = `DISABLE,
  localparam int IDX  = $clog2(DEPTH),
  localparam int CNT  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             flush,
  input  logic             alloc_req,
  output logic             alloc_ack,
  output logic             alloc_avail,
  output logic [IDX-1:0]   alloc_idx,
  input  logic [DEPTH-1:0] rel_vec,
  output logic [DEPTH-1:0] busy,
  output logic [CNT-1:0]   free_cnt,
  output logic             full,
  output logic             empty,
  output logic             err_rel
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNT-1:0]   free_cnt_q, free_cnt_d;
  logic             err_rel_q, err_rel_d;
  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] rel_eff;
  logic [DEPTH-1:0] grant_vec;
  logic [CNT:0]     rel_pop;
  logic [CNT:0]     cnt_wide;

  assign free_vec    = ~busy_q;
  assign alloc_avail = |free_vec;
  assign alloc_ack   = alloc_req & alloc_avail & ~flush;

  // Later loop iterations win, so scan order sets the priority direction.
  always_comb begin
    alloc_idx = '0;
    if (MSB) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (free_vec[i]) alloc_idx = IDX'(i);
      end
    end else begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (free_vec[i]) alloc_idx = IDX'(i);
      end
    end
  end

  assign rel_eff = rel_vec & busy_q;

  always_comb begin
    rel_pop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel_pop = rel_pop + (CNT+1)'(rel_eff[i]);
    end
  end

  assign grant_vec = alloc_ack ? ({{(DEPTH-1){1'b0}}, 1'b1} << alloc_idx) : '0;
  assign cnt_wide  = {1'b0, free_cnt_q} + rel_pop - (CNT+1)'(alloc_ack);

  always_comb begin
    busy_d     = (busy_q & ~rel_eff) | grant_vec;
    free_cnt_d = cnt_wide[CNT-1:0];
    err_rel_d  = |(rel_vec & ~busy_q);
    if (flush) begin
      busy_d     = '0;
      free_cnt_d = CNT'(DEPTH);
      err_rel_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      busy_q     <= '0;
      free_cnt_q <= CNT'(DEPTH);
      err_rel_q  <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      free_cnt_q <= free_cnt_d;
      err_rel_q  <= err_rel_d;
    end
  end

  assign busy     = busy_q;
  assign free_cnt = free_cnt_q;
  assign err_rel  = err_rel_q;
  assign full     = (free_cnt_q == '0);
  assign empty    = (free_cnt_q == CNT'(DEPTH));

endmodule

// File: tb/tb_slot_alloc.sv
// Directed bench for slot_alloc: one LSB-first and one MSB-first instance, DEPTH=16.
`ifndef DISABLE
`define DISABLE 1'b0
`endif
`ifndef ENABLE
`define ENABLE 1'b1
`endif

module tb_slot_alloc;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;

  logic        flush0 = 1'b0, req0 = 1'b0;
  logic [15:0] rel0 = '0;
  logic        ack0, avail0, full0, empty0, err0;
  logic [3:0]  idx0;
  logic [15:0] busy0;
  logic [4:0]  cnt0;

  logic        flush1 = 1'b0, req1 = 1'b0;
  logic [15:0] rel1 = '0;
  logic        ack1, avail1, full1, empty1, err1;
  logic [3:0]  idx1;
  logic [15:0] busy1;
  logic [4:0]  cnt1;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  slot_alloc #(.DEPTH(16), .MSB(`DISABLE)) u_lsb (
    .clk(clk), .reset_(reset_), .flush(flush0), .alloc_req(req0),
    .alloc_ack(ack0), .alloc_avail(avail0), .alloc_idx(idx0), .rel_vec(rel0),
    .busy(busy0), .free_cnt(cnt0), .full(full0), .empty(empty0), .err_rel(err0)
  );

  slot_alloc #(.DEPTH(16), .MSB(`ENABLE)) u_msb (
    .clk(clk), .reset_(reset_), .flush(flush1), .alloc_req(req1),
    .alloc_ack(ack1), .alloc_avail(avail1), .alloc_idx(idx1), .rel_vec(rel1),
    .busy(busy1), .free_cnt(cnt1), .full(full1), .empty(empty1), .err_rel(err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let inputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset_ = 1'b1;
    #1;
    chk("rst_busy",  busy0,  32'h0);
    chk("rst_cnt",   cnt0,   32'd16);
    chk("rst_empty", empty0, 32'd1);
    chk("rst_full",  full0,  32'd0);
    chk("rst_avail", avail0, 32'd1);
    chk("rst_idx",   idx0,   32'd0);
    chk("rst_err",   err0,   32'd0);
    chk("rst_idx_msb", idx1, 32'd15);

    // Fill from empty: 16 grants in ascending order, then none.
    for (int c = 1; c <= 17; c++) begin
      req0 = 1'b1;
      #1;
      if (c <= 16) begin
        chk("fill_ack", ack0, 32'd1);
        chk("fill_idx", idx0, c - 1);
      end else begin
        chk("fill_ack17",  ack0,  32'd0);
        chk("fill_full",   full0, 32'd1);
        chk("fill_cnt",    cnt0,  32'd0);
        chk("fill_busy",   busy0, 32'hFFFF);
      end
      tick();
    end

    // Release while full: no same-cycle grant, slot offered next cycle.
    req0 = 1'b1; rel0 = 16'h0024;
    #1;
    chk("relfull_ack", ack0, 32'd0);
    tick();
    req0 = 1'b0; rel0 = '0;
    #1;
    chk("relfull_busy", busy0, 32'hFFDB);
    chk("relfull_cnt",  cnt0,  32'd2);
    chk("relfull_idx",  idx0,  32'd2);
    req0 = 1'b1;
    #1;
    chk("realloc_ack0", ack0, 32'd1);
    chk("realloc_idx0", idx0, 32'd2);
    tick();
    chk("realloc_ack1", ack0, 32'd1);
    chk("realloc_idx1", idx0, 32'd5);
    tick();
    req0 = 1'b0;
    #1;
    chk("refull_full", full0, 32'd1);

    // Flush, then build busy=000F.
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0;
    chk("flush_empty", empty0, 32'd1);
    req0 = 1'b1;
    repeat (4) tick();
    req0 = 1'b0;
    #1;
    chk("pre_sim_busy", busy0, 32'h000F);

    // Simultaneous alloc and release.
    req0 = 1'b1; rel0 = 16'h0003;
    #1;
    chk("sim_ack", ack0, 32'd1);
    chk("sim_idx", idx0, 32'd4);
    tick();
    req0 = 1'b0; rel0 = '0;
    #1;
    chk("sim_busy", busy0, 32'h001C);
    chk("sim_cnt",  cnt0,  32'd13);
    chk("sim_err",  err0,  32'd0);

    // Stray release from busy=0001.
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    #1;
    chk("pre_stray_busy", busy0, 32'h0001);
    rel0 = 16'h0003;
    tick();
    rel0 = '0;
    #1;
    chk("stray_busy", busy0, 32'h0);
    chk("stray_cnt",  cnt0,  32'd16);
    chk("stray_err1", err0,  32'd1);
    tick();
    chk("stray_err0", err0,  32'd0);

    // MSB-first instance: descending grants, then flush beats a request.
    req1 = 1'b1;
    #1;
    chk("msb_idx15", idx1, 32'd15);
    chk("msb_ack15", ack1, 32'd1);
    tick();
    chk("msb_idx14", idx1, 32'd14);
    tick();
    chk("msb_idx13", idx1, 32'd13);
    chk("msb_ack13", ack1, 32'd1);
    tick();
    flush1 = 1'b1;
    #1;
    chk("msb_flush_ack", ack1, 32'd0);
    tick();
    flush1 = 1'b0; req1 = 1'b0;
    #1;
    chk("msb_flush_busy", busy1, 32'h0);
    chk("msb_flush_cnt",  cnt1,  32'd16);
    chk("msb_flush_idx",  idx1,  32'd15);

    // Asynchronous reset mid-operation clears state without a clock edge.
    req0 = 1'b1;
    tick();
    tick();
    req0 = 1'b0;
    #1;
    chk("pre_arst_busy", busy0, 32'h0003);
    #1 reset_ = 1'b0;
    #1;
    chk("arst_busy", busy0, 32'h0);
    chk("arst_cnt",  cnt0,  32'd16);
    reset_ = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
